// File: rtl/ps2_mouse_init_ctrl_if.sv
// Byte-level handshake between the mouse init controller (master) and the PS/2 transceiver (slave).
interface ps2_mouse_init_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_write;
  logic       tx_busy;
  logic       tx_error;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output tx_data, tx_write, input tx_busy, tx_error, rx_data, rx_valid);
  modport slave  (input tx_data, tx_write, output tx_busy, tx_error, rx_data, rx_valid);
endinterface

// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse power-up sequencer: FF / F3 rate / F4 with response checking, resend and retry.
// Define INTELLIMOUSE_EN to add the wheel knock sequence and F2 ID probe.
module ps2_mouse_init_ctrl #(
  parameter logic [7:0] SAMPLE_RATE    = 8'd100,
  parameter int         POWERUP_CYCLES = 65000,
  parameter int         RESP_TIMEOUT   = 2000000,
  parameter int         BAT_TIMEOUT    = 40000000,
  parameter int         MAX_RETRIES    = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         restart,
  ps2_mouse_init_ctrl_if.master        ps2,
  output logic                         streaming,
  output logic                         init_error,
  output logic [3:0]                   retry_cnt,
  output logic                         has_wheel
);
`ifdef INTELLIMOUSE_EN
  localparam logic [3:0] LAST_STEP = 4'd10;
  localparam logic [3:0] ID_STEP   = 4'd7;
`else
  localparam logic [3:0] LAST_STEP = 4'd3;
`endif
  localparam logic [25:0] PWR_LIM   = 26'(POWERUP_CYCLES - 1);
  localparam logic [25:0] RESP_LIM  = 26'(RESP_TIMEOUT);
  localparam logic [25:0] BAT_LIM   = 26'(BAT_TIMEOUT);
  localparam logic [3:0]  RETRY_LIM = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {PWRUP, SEND, WAIT_TX, WAIT_RESP, DONE, ERROR} state_t;

  function automatic logic [7:0] step_byte(input logic [3:0] s);
`ifdef INTELLIMOUSE_EN
    case (s)
      4'd0:                   return 8'hFF;
      4'd1, 4'd3, 4'd5, 4'd8: return 8'hF3;
      4'd2:                   return 8'hC8;
      4'd4:                   return 8'h64;
      4'd6:                   return 8'h50;
      4'd7:                   return 8'hF2;
      4'd9:                   return SAMPLE_RATE;
      default:                return 8'hF4;
    endcase
`else
    case (s)
      4'd0:    return 8'hFF;
      4'd1:    return 8'hF3;
      4'd2:    return SAMPLE_RATE;
      default: return 8'hF4;
    endcase
`endif
  endfunction

  state_t      state, state_n;
  logic [3:0]  step, step_n;
  logic [1:0]  ridx, ridx_n, last_ridx;
  logic        resent, resent_n, busy_seen, busy_seen_n;
  logic [25:0] tmr, tmr_n;
  logic [3:0]  retry_n;
  logic        streaming_n, init_error_n, tx_write_q, tx_write_n;
  logic [7:0]  tx_data_q, tx_data_n, exp_byte;
  logic        fail, timeout, is_id, byte_ok;
`ifdef INTELLIMOUSE_EN
  logic        wheel, wheel_n;
  assign has_wheel = wheel;
`else
  assign has_wheel = 1'b0;
`endif

  assign ps2.tx_data  = tx_data_q;
  assign ps2.tx_write = tx_write_q;

  // Response ROM: FF answers FA AA 00, F2 answers FA <id>, everything else FA.
  always_comb begin
    exp_byte  = 8'hFA;
    last_ridx = 2'd0;
    is_id     = 1'b0;
    if (step == 4'd0) begin
      last_ridx = 2'd2;
      if (ridx == 2'd1)      exp_byte = 8'hAA;
      else if (ridx == 2'd2) exp_byte = 8'h00;
    end
`ifdef INTELLIMOUSE_EN
    if (step == ID_STEP) begin
      last_ridx = 2'd1;
      is_id     = (ridx == 2'd1);
    end
`endif
    timeout = tmr >= (((step == 4'd0) && (ridx != 2'd0)) ? BAT_LIM : RESP_LIM);
    byte_ok = is_id ? (ps2.rx_data == 8'h00 || ps2.rx_data == 8'h03) : (ps2.rx_data == exp_byte);
  end

  always_comb begin
    state_n      = state;
    step_n       = step;
    ridx_n       = ridx;
    resent_n     = resent;
    busy_seen_n  = busy_seen;
    tmr_n        = (tmr == '1) ? tmr : tmr + 26'd1;
    retry_n      = retry_cnt;
    streaming_n  = streaming;
    init_error_n = init_error;
    tx_write_n   = 1'b0;
    tx_data_n    = tx_data_q;
    fail         = 1'b0;
`ifdef INTELLIMOUSE_EN
    wheel_n      = wheel;
`endif
    case (state)
      PWRUP: if (tmr >= PWR_LIM) state_n = SEND;
      SEND: if (!ps2.tx_busy) begin
        tx_write_n  = 1'b1;
        tx_data_n   = step_byte(step);
        ridx_n      = 2'd0;
        busy_seen_n = 1'b0;
        tmr_n       = '0;
        state_n     = WAIT_TX;
      end
      // busy may rise a cycle after the strobe, so require having seen it high first
      WAIT_TX: begin
        busy_seen_n = busy_seen | ps2.tx_busy;
        if (ps2.tx_error || timeout)          fail = 1'b1;
        else if (busy_seen && !ps2.tx_busy)   state_n = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (ps2.rx_valid) begin
          if (ps2.rx_data == 8'hFE) begin
            if (resent) fail = 1'b1;
            else begin
              resent_n = 1'b1;
              state_n  = SEND;
            end
          end else if (byte_ok) begin
            tmr_n = '0;
`ifdef INTELLIMOUSE_EN
            if (is_id) wheel_n = ps2.rx_data[0];
`endif
            if (ridx != last_ridx) ridx_n = ridx + 2'd1;
            else if (step == LAST_STEP) begin
              state_n     = DONE;
              streaming_n = 1'b1;
            end else begin
              step_n   = step + 4'd1;
              resent_n = 1'b0;
              state_n  = SEND;
            end
          end else fail = 1'b1;
        end else if (timeout) fail = 1'b1;
      end
      default: ;
    endcase

    if (fail) begin
      if (retry_cnt < RETRY_LIM) begin
        retry_n  = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;
        step_n   = 4'd0;
        resent_n = 1'b0;
        state_n  = SEND;
      end else begin
        state_n      = ERROR;
        init_error_n = 1'b1;
        streaming_n  = 1'b0;
      end
    end

    // restart overrides everything, including a byte arriving in the same cycle
    if (restart) begin
      state_n      = SEND;
      step_n       = 4'd0;
      ridx_n       = 2'd0;
      resent_n     = 1'b0;
      retry_n      = 4'd0;
      streaming_n  = 1'b0;
      init_error_n = 1'b0;
      tx_write_n   = 1'b0;
`ifdef INTELLIMOUSE_EN
      wheel_n      = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= PWRUP;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step       <= 4'd0;
      ridx       <= 2'd0;
      resent     <= 1'b0;
      busy_seen  <= 1'b0;
      tmr        <= '0;
      retry_cnt  <= 4'd0;
      streaming  <= 1'b0;
      init_error <= 1'b0;
      tx_write_q <= 1'b0;
      tx_data_q  <= 8'h00;
`ifdef INTELLIMOUSE_EN
      wheel      <= 1'b0;
`endif
    end else begin
      step       <= step_n;
      ridx       <= ridx_n;
      resent     <= resent_n;
      busy_seen  <= busy_seen_n;
      tmr        <= tmr_n;
      retry_cnt  <= retry_n;
      streaming  <= streaming_n;
      init_error <= init_error_n;
      tx_write_q <= tx_write_n;
      tx_data_q  <= tx_data_n;
`ifdef INTELLIMOUSE_EN
      wheel      <= wheel_n;
`endif
    end
  end
endmodule
